// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop line synchronizer, tick divider, framing FSM,
// optional parity check and a one-word output holding register with overrun reporting.
module uart_rx_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK50MHz,
    input  logic                 RESET_N,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int TICK_RATE = BAUD * OVERSAMPLE;
    localparam int DIV       = (CLK_HZ + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SUB_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_HALF_M1 = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST   = 1'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Odd mode wants an odd number of ones over data plus parity bit, even mode an even number.
    function automatic logic parity_error(input logic [DATA_BITS-1:0] word, input logic pbit);
        logic ones_odd;
        ones_odd = ^{word, pbit};
        if (PARITY == 1) begin
            parity_error = ~ones_odd;
        end else begin
            parity_error = ones_odd;
        end
    endfunction

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [SUB_W-1:0]     sub_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 stop_cnt_r;
    logic [2:0]           state_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 par_pend_r;
    logic                 fe_pend_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 overrun_r;
    logic                 busy_r;

    logic       tick_s;
    logic       sub_term_s;
    logic       sample_s;
    logic [2:0] state_nxt_s;
    logic       shift_en_s;
    logic       par_en_s;
    logic       stop_first_s;
    logic       final_s;
    logic       fe_now_s;
    logic       load_s;

    // Line synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Tick, sub-count terminal and bit-sample strobes.
    always_comb begin
        tick_s = (div_cnt_r == DIV_LAST);
        if (state_r == ST_START) begin
            sub_term_s = (sub_cnt_r == SUB_HALF_M1);
        end else begin
            sub_term_s = (sub_cnt_r == SUB_LAST);
        end
        if ((state_r == ST_START) || (state_r == ST_DATA) ||
            (state_r == ST_PARITY) || (state_r == ST_STOP)) begin
            sample_s = tick_s && sub_term_s;
        end else begin
            sample_s = 1'b0;
        end
    end

    // Framing FSM next-state and per-state sample strobes.
    always_comb begin
        state_nxt_s  = state_r;
        shift_en_s   = 1'b0;
        par_en_s     = 1'b0;
        stop_first_s = 1'b0;
        final_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    state_nxt_s = rx_sync_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_nxt_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    par_en_s    = 1'b1;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    stop_first_s = (stop_cnt_r == 1'b0);
                    if (stop_cnt_r == STOP_LAST) begin
                        final_s     = 1'b1;
                        state_nxt_s = rx_sync_r ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_sync_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Only the first stop bit decides the frame error; a later low stop bit is ignored.
    always_comb begin
        if (stop_first_s) begin
            fe_now_s = ~rx_sync_r;
        end else begin
            fe_now_s = fe_pend_r;
        end
        load_s = final_s && (!valid_r || DATA_READY);
    end

    // State register and registered busy flag.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Sub-tick counter is held at zero outside the bit-timed states.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            sub_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) || (state_r == ST_WAIT_HIGH)) begin
            sub_cnt_r <= '0;
        end else if (tick_s) begin
            if (sub_term_s) begin
                sub_cnt_r <= '0;
            end else begin
                sub_cnt_r <= sub_cnt_r + SUB_W'(1);
            end
        end
    end

    // Data and stop bit counters.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
        end else begin
            if (state_r != ST_DATA) begin
                bit_cnt_r <= '0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
            if (state_r != ST_STOP) begin
                stop_cnt_r <= 1'b0;
            end else if (sample_s) begin
                stop_cnt_r <= stop_cnt_r + 1'b1;
            end
        end
    end

    // Shift register (LSB first) and pending per-frame error flags.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            shreg_r    <= '0;
            par_pend_r <= 1'b0;
            fe_pend_r  <= 1'b0;
        end else begin
            if (shift_en_s) begin
                shreg_r <= {rx_sync_r, shreg_r[DATA_BITS-1:1]};
            end
            if (par_en_s) begin
                par_pend_r <= parity_error(shreg_r, rx_sync_r);
            end
            if (stop_first_s) begin
                fe_pend_r <= ~rx_sync_r;
            end
        end
    end

    // Output holding register; a word arriving while the previous one is unconsumed is dropped.
    always_ff @(posedge CLK50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= shreg_r;
                perr_r  <= par_pend_r;
                ferr_r  <= fe_now_s;
                valid_r <= 1'b1;
            end else if (valid_r && DATA_READY) begin
                valid_r <= 1'b0;
            end
            overrun_r <= final_s && !load_s;
        end
    end

    assign DATA       = data_r;
    assign DATA_VALID = valid_r;
    assign PARITY_ERR = perr_r;
    assign FRAME_ERR  = ferr_r;
    assign OVERRUN    = overrun_r;
    assign BUSY       = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: one default-rate instance plus two fast-rate
// instances (8N1 and even parity) sharing clock and reset.
module tb_uart_rx_core;

    localparam int BIT_D = 5216;
    localparam int BIT_F = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_d, rx_f, rx_p;
    logic rdy_d, rdy_f, rdy_p;
    logic [7:0] data_d, data_f, data_p;
    logic valid_d, perr_d, ferr_d, ovr_d, busy_d;
    logic valid_f, perr_f, ferr_f, ovr_f, busy_f;
    logic valid_p, perr_p, ferr_p, ovr_p, busy_p;

    int vecs = 0;
    int errs = 0;
    int vcnt_d = 0, vcnt_f = 0, vcnt_p = 0, ocnt_f = 0;
    int snap_v, snap_o;

    always #5 clk = ~clk;

    uart_rx_core u_dflt (
        .CLK50MHz(clk), .RESET_N(rst_n), .RX(rx_d), .DATA(data_d), .DATA_VALID(valid_d),
        .DATA_READY(rdy_d), .PARITY_ERR(perr_d), .FRAME_ERR(ferr_d), .OVERRUN(ovr_d), .BUSY(busy_d)
    );

    uart_rx_core #(.CLK_HZ(614400)) u_fast (
        .CLK50MHz(clk), .RESET_N(rst_n), .RX(rx_f), .DATA(data_f), .DATA_VALID(valid_f),
        .DATA_READY(rdy_f), .PARITY_ERR(perr_f), .FRAME_ERR(ferr_f), .OVERRUN(ovr_f), .BUSY(busy_f)
    );

    uart_rx_core #(.CLK_HZ(614400), .PARITY(2)) u_par (
        .CLK50MHz(clk), .RESET_N(rst_n), .RX(rx_p), .DATA(data_p), .DATA_VALID(valid_p),
        .DATA_READY(rdy_p), .PARITY_ERR(perr_p), .FRAME_ERR(ferr_p), .OVERRUN(ovr_p), .BUSY(busy_p)
    );

    // Count valid-high and overrun-high cycles per instance
    always @(negedge clk) begin
        if (valid_d) vcnt_d <= vcnt_d + 1;
        if (valid_f) vcnt_f <= vcnt_f + 1;
        if (valid_p) vcnt_p <= vcnt_p + 1;
        if (ovr_f)   ocnt_f <= ocnt_f + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int line, input logic v);
        case (line)
            0: rx_d = v;
            1: rx_f = v;
            2: rx_p = v;
            default: ;
        endcase
    endtask

    task automatic send_bits(input int line, input logic [15:0] pat, input int nbits, input int period);
        for (int i = 0; i < nbits; i++) begin
            set_rx(line, pat[i]);
            repeat (period) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rx_d = 1'b1; rx_f = 1'b1; rx_p = 1'b1;
        rdy_d = 1'b1; rdy_f = 1'b1; rdy_p = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dflt", {data_d, valid_d, perr_d, ferr_d, ovr_d, busy_d}, 32'h0);
        chk("reset_fast", {data_f, valid_f, perr_f, ferr_f, ovr_f, busy_f}, 32'h0);
        chk("reset_par",  {data_p, valid_p, perr_p, ferr_p, ovr_p, busy_p}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 8N1 at the default rate
        snap_v = vcnt_d;
        send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, BIT_D);
        chk("a5_data", data_d, 32'hA5);
        chk("a5_valid_cycles", vcnt_d - snap_v, 32'd1);
        chk("a5_flags", {valid_d, perr_d, ferr_d, busy_d}, 32'h0);

        // Start-bit glitch: low 2000 clocks then high
        snap_v = vcnt_d;
        set_rx(0, 1'b0);
        repeat (1000) @(negedge clk);
        chk("glitch_busy_set", busy_d, 32'd1);
        repeat (1000) @(negedge clk);
        set_rx(0, 1'b1);
        for (int i = 0; i < 720 && busy_d; i++) @(negedge clk);
        chk("glitch_busy_clear", busy_d, 32'd0);
        chk("glitch_no_valid", vcnt_d - snap_v, 32'd0);
        chk("glitch_data_kept", data_d, 32'hA5);

        // Even parity: 0x03 with parity 1 is wrong, with parity 0 is right
        send_bits(2, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, BIT_F);
        chk("par_bad_data", data_p, 32'h03);
        chk("par_bad_err", perr_p, 32'd1);
        send_bits(2, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, BIT_F);
        chk("par_good_err", perr_p, 32'd0);
        send_bits(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, BIT_F);
        chk("par_07_p0", {data_p, perr_p}, {23'b0, 8'h07, 1'b1});
        chk("par_frame", ferr_p, 32'd0);

        // 0x55 with low stop bit and line held low for two bit periods
        snap_v = vcnt_f;
        send_bits(1, {6'b0, 1'b0, 8'h55, 1'b0}, 10, BIT_F);
        repeat (BIT_F) @(negedge clk);
        chk("brk_data", data_f, 32'h55);
        chk("brk_ferr", ferr_f, 32'd1);
        chk("brk_wait_high", busy_f, 32'd1);
        set_rx(1, 1'b1);
        repeat (2 * BIT_F) @(negedge clk);
        chk("brk_idle", busy_f, 32'd0);
        chk("brk_one_word", vcnt_f - snap_v, 32'd1);
        send_bits(1, {6'b0, 1'b1, 8'h81, 1'b0}, 10, BIT_F);
        chk("brk_recover", {data_f, ferr_f, perr_f}, {22'b0, 8'h81, 2'b00});

        // Overrun: two back-to-back frames with no consumer
        rdy_f = 1'b0;
        snap_o = ocnt_f;
        send_bits(1, {6'b0, 1'b1, 8'h11, 1'b0}, 10, BIT_F);
        send_bits(1, {6'b0, 1'b1, 8'h22, 1'b0}, 10, BIT_F);
        chk("ovr_data_held", data_f, 32'h11);
        chk("ovr_valid", valid_f, 32'd1);
        chk("ovr_pulses", ocnt_f - snap_o, 32'd1);
        rdy_f = 1'b1;
        @(negedge clk);
        rdy_f = 1'b0;
        chk("ovr_consumed", valid_f, 32'd0);
        rdy_f = 1'b1;

        // Reset in the middle of data bit 4, then a clean 0x3C
        send_bits(1, 16'h001E, 5, BIT_F);
        set_rx(1, 1'b0);
        repeat (30) @(negedge clk);
        chk("midrst_busy_before", busy_f, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {data_f, valid_f, perr_f, ferr_f, ovr_f, busy_f}, 32'h0);
        set_rx(1, 1'b1);
        repeat (10) @(negedge clk);
        chk("midrst_hold", {data_f, valid_f, perr_f, ferr_f, ovr_f, busy_f}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        snap_v = vcnt_f;
        send_bits(1, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, BIT_F);
        chk("after_rst_data", data_f, 32'h3C);
        chk("after_rst_flags", {perr_f, ferr_f, busy_f}, 32'h0);
        chk("after_rst_one_word", vcnt_f - snap_v, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
